axi_read_mem_slave: RTL and testbench
=====================================

// Module: axi_read_mem_slave
// PURPOSE
// - AXI3 read-only memory slave; sits directly downstream of an interconnect slave port (S0/S1 AR/R channels).
// - Buffers up to NUM_OUTSTANDING_TRANS read addresses, returns bursts in order from a flop-based word array.
// - A sideband load port preloads contents for system-level read tests.
// PARAMETERS
// - M                     2    masters upstream; widens ID by $clog2(M)
// - ID_WIDTH              4    master-side ID width; slave ID width IDW = ID_WIDTH+$clog2(M)
// - BUS_WIDTH             32   data width; byte lanes B = BUS_WIDTH/8
// - ADDR_WIDTH            32   address width
// - MEM_DEPTH             256  words in the array (power of 2)
// - NUM_OUTSTANDING_TRANS 2    AR queue depth (>=1)
// PORTS
// - clk      in   1                   clock; all logic on rising edge
// - clr      in   1                   synchronous, active-high reset
// - S_ARID   in   IDW                 read address ID
// - S_ARADDR in   ADDR_WIDTH          byte address of first beat
// - S_ARLEN  in   4                   beats-1
// - S_ARSIZE in   3                   bytes per beat = 1<<S_ARSIZE
// - S_ARBURST in  2                   00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
// - S_ARVALID in  1                   address valid
// - S_ARREADY out 1                   address ready
// - S_RID    out  IDW                 ID of the current burst
// - S_RDATA  out  BUS_WIDTH           read data
// - S_RRESP  out  4                   [1:0] response, [3:2] always 0
// - S_RLAST  out  1                   final beat
// - S_RVALID out  1                   data valid
// - S_RREADY in   1                   data ready
// - ld_en    in   1                   preload write strobe
// - ld_addr  in   $clog2(MEM_DEPTH)   preload word index
// - ld_data  in   BUS_WIDTH           preload data
// BEHAVIOUR
// - Reset (clr sampled high): queue empty, FSM IDLE; S_ARREADY=0 while clr high, 1 the cycle after; S_RVALID=0, S_RLAST=0, S_RID=0, S_RRESP=0, S_RDATA=0. Array NOT reset; contents survive clr.
// - AR queue: FIFO of {id,addr,len,size,burst}; S_ARREADY = !clr && !full; push on ARVALID&&ARREADY. Full blocks push even if a pop occurs that cycle.
// - FSM IDLE: queue non-empty -> pop, load id/addr/beat count=len, go BURST. BURST: S_RVALID=1, S_RLAST=(count==0).
// - Beat accept (RVALID&&RREADY): not last -> count-1, advance addr; last -> pop next entry if queue non-empty (stay BURST, zero-bubble), else IDLE.
// - Latency: AR handshake in cycle t, FSM IDLE -> first S_RVALID in cycle t+2.
// - Addr advance: INCR addr+(1<<size); FIXED unchanged; WRAP len in {1,3,7,15}: wraps within aligned (len+1)<<size region, other len -> INCR. Arithmetic modulo 2^ADDR_WIDTH.
// - Word index = addr[$clog2(B) +: $clog2(MEM_DEPTH)]; sub-word bits ignored (full word returned).
// - S_RDATA = S_RVALID ? mem[index] : 0. S_RID/S_RRESP/S_RLAST/S_RDATA held stable while RVALID && !RREADY.
// - Preload: ld_en writes mem[ld_addr] at the edge; a beat reading that word in the same cycle shows old data, new from next cycle.
// - clr mid-burst: burst and queued entries discarded, S_RVALID low from the cycle after clr sampled.
// CONFIGURATION
// - ERR_RESP_EN defined: any addr bit above the index range nonzero -> beat returns S_RRESP=2'b10 (SLVERR), S_RDATA=0; burst length unchanged.
// - ERR_RESP_EN undefined: upper address bits ignored (aliasing), S_RRESP always 2'b00.
// TESTING
// - Preload mem[0..3]=0xA0..0xA3; AR id=5 addr=0x0 len=3 size=2 INCR -> 0xA0,0xA1,0xA2,0xA3, RID=5, RLAST on beat 4, first RVALID 2 cycles after handshake.
// - ARs id=1 and id=2 back-to-back, third ARVALID held -> ARREADY=0 with 2 queued; id=1 burst then id=2 burst with no idle cycle.
// - RREADY toggled 1/0 each cycle on len=3 burst -> RDATA/RID/RLAST unchanged in stall cycles, 4 beats total.
// - WRAP len=3 size=2 addr=0x8 -> words 2,3,0,1; FIXED len=2 addr=0x4 -> mem[1] three times.
// - clr asserted after beat 2 of a len=7 burst with one entry queued -> RVALID=0 next cycle, no further beats, ARREADY=1 after clr.
// - ERR_RESP_EN, MEM_DEPTH=256: addr=0x400 len=1 -> 2 beats RRESP=2'b10, RDATA=0; without macro -> mem[0],mem[1], RRESP=0.

Source files
------------

// File: rtl/axi_read_mem_slave_if.sv
// AXI3 read-only slave bus bundle (AR and R channels) for axi_read_mem_slave.
// Signal names follow the upstream interconnect's slave-port naming.
interface axi_read_mem_slave_if #(
    parameter int unsigned IDW        = 5,
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [IDW-1:0]        S_ARID;
    logic [ADDR_WIDTH-1:0] S_ARADDR;
    logic [3:0]            S_ARLEN;
    logic [2:0]            S_ARSIZE;
    logic [1:0]            S_ARBURST;
    logic                  S_ARVALID;
    logic                  S_ARREADY;
    logic [IDW-1:0]        S_RID;
    logic [BUS_WIDTH-1:0]  S_RDATA;
    logic [3:0]            S_RRESP;
    logic                  S_RLAST;
    logic                  S_RVALID;
    logic                  S_RREADY;

    modport slave (
        input  S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
        output S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID
    );

    modport master (
        output S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
        input  S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID
    );
endinterface

// File: rtl/axi_read_mem_slave.sv
// AXI3 read-only memory slave: queued AR requests, in-order bursts from a flop array with preload.
// Optional macro ERR_RESP_EN: addresses beyond the array return SLVERR with zero data.
module axi_read_mem_slave #(
    parameter int unsigned M                     = 2,
    parameter int unsigned ID_WIDTH              = 4,
    parameter int unsigned BUS_WIDTH             = 32,
    parameter int unsigned ADDR_WIDTH            = 32,
    parameter int unsigned MEM_DEPTH             = 256,
    parameter int unsigned NUM_OUTSTANDING_TRANS = 2
) (
    input  logic                         clk,
    input  logic                         clr,
    axi_read_mem_slave_if.slave          bus,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [BUS_WIDTH-1:0]         ld_data
);
    localparam int unsigned IDW = ID_WIDTH + $clog2(M);
    localparam int unsigned LB  = $clog2(BUS_WIDTH / 8);
    localparam int unsigned IW  = $clog2(MEM_DEPTH);
    localparam int unsigned QD  = NUM_OUTSTANDING_TRANS;
    localparam int unsigned PW  = (QD > 1) ? $clog2(QD) : 1;
    localparam int unsigned CW  = $clog2(QD + 1);

    typedef enum logic {StIdle, StBurst} state_e;

    logic [BUS_WIDTH-1:0] mem [MEM_DEPTH];

    logic [IDW-1:0]        q_id    [QD];
    logic [ADDR_WIDTH-1:0] q_addr  [QD];
    logic [3:0]            q_len   [QD];
    logic [2:0]            q_size  [QD];
    logic [1:0]            q_burst [QD];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         q_cnt_q;
    logic                  q_full, q_empty, push, pop;

    state_e                state_q, state_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            len_q, len_d, count_q, count_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;

    logic [ADDR_WIDTH-1:0] beat_bytes, wrap_mask, addr_next;
    logic                  wrap_ok, valid, addr_err;
    logic [IW-1:0]         word_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Preload port; contents deliberately survive clr.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    assign q_full        = (q_cnt_q == CW'(QD));
    assign q_empty       = (q_cnt_q == '0);
    assign bus.S_ARREADY = !clr && !q_full;
    assign push          = bus.S_ARVALID && bus.S_ARREADY;

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr_q]    <= bus.S_ARID;
            q_addr[wr_ptr_q]  <= bus.S_ARADDR;
            q_len[wr_ptr_q]   <= bus.S_ARLEN;
            q_size[wr_ptr_q]  <= bus.S_ARSIZE;
            q_burst[wr_ptr_q] <= bus.S_ARBURST;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            q_cnt_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   q_cnt_q <= q_cnt_q + CW'(1);
                2'b01:   q_cnt_q <= q_cnt_q - CW'(1);
                default: q_cnt_q <= q_cnt_q;
            endcase
        end
    end

    // Next beat address; WRAP stays inside the aligned (len+1)<<size window.
    always_comb begin
        beat_bytes = ADDR_WIDTH'(1) << size_q;
        wrap_mask  = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        wrap_ok    = len_q inside {4'd1, 4'd3, 4'd7, 4'd15};
        if (burst_q == 2'b00) begin
            addr_next = addr_q;
        end else if (burst_q == 2'b10 && wrap_ok) begin
            addr_next = (addr_q & ~wrap_mask) | ((addr_q + beat_bytes) & wrap_mask);
        end else begin
            addr_next = addr_q + beat_bytes;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        count_d = count_q;
        size_d  = size_q;
        burst_d = burst_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (bus.S_RREADY) begin
                    if (count_q != 4'd0) begin
                        count_d = count_q - 4'd1;
                        addr_d  = addr_next;
                    end else if (!q_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            id_d    = q_id[rd_ptr_q];
            addr_d  = q_addr[rd_ptr_q];
            len_d   = q_len[rd_ptr_q];
            count_d = q_len[rd_ptr_q];
            size_d  = q_size[rd_ptr_q];
            burst_d = q_burst[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

    assign word_idx = addr_q[LB +: IW];
`ifdef ERR_RESP_EN
    assign addr_err = |(addr_q >> (LB + IW));
`else
    assign addr_err = 1'b0;
`endif

    assign valid        = (state_q == StBurst);
    assign bus.S_RVALID = valid;
    assign bus.S_RLAST  = valid && (count_q == 4'd0);
    assign bus.S_RID    = valid ? id_q : '0;
    assign bus.S_RRESP  = {2'b00, (valid && addr_err) ? 2'b10 : 2'b00};
    assign bus.S_RDATA  = (valid && !addr_err) ? mem[word_idx] : '0;
endmodule

// File: tb/tb_axi_read_mem_slave.sv
// Randomized self-checking bench for axi_read_mem_slave against a beat-list reference model.
// Honours ERR_RESP_EN the same way the design does.
module tb_axi_read_mem_slave;
    logic        clk = 1'b0;
    logic        clr;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    axi_read_mem_slave_if #(.IDW(5), .BUS_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    axi_read_mem_slave dut (
        .clk     (clk),
        .clr     (clr),
        .bus     (bus),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  id;
        int unsigned idx;
        bit          err;
        bit          last;
    } beat_t;

    int          n_total = 0;
    int          n_bad   = 0;
    beat_t       exp_q[$];
    logic [31:0] mem_model [256];
    bit          ld_seen;
    int          rr_mode = 0;    // 0 hold low, 1 always high, 2 toggle, 3 random
    int          beats   = 0;
    int          bubbles = 0;
    bit          bubble_win = 0;
    bit          stall_q = 0;
    logic [4:0]  prev_rid;
    logic [31:0] prev_rdata;
    logic [3:0]  prev_rresp;
    logic        prev_rlast;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Byte address of beat i, straight from the burst-type definitions.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input logic [1:0] burst, input int i);
        longint unsigned s, bytes, region, lo, off;
        s     = start;
        bytes = longint'(1) << size;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            region = longint'(len + 1) * bytes;
            lo     = s - (s % region);
            off    = (s - lo + longint'(i) * bytes) % region;
            return 32'(lo + off);
        end
        return 32'(s + longint'(i) * bytes);
    endfunction

    always @(posedge clk) begin
        ld_seen = ld_en;
        if (ld_en) mem_model[ld_addr] = ld_data;
    end

    // Scoreboard: expands accepted ARs into beats and checks every accepted R beat.
    always @(negedge clk) begin
        if (clr) begin
            exp_q.delete();
            stall_q = 0;
        end else begin
            if (stall_q && !ld_seen) begin
                check_eq("hold_rvalid", bus.S_RVALID, 1);
                check_eq("hold_rid", bus.S_RID, prev_rid);
                check_eq("hold_rdata", bus.S_RDATA, prev_rdata);
                check_eq("hold_rresp", bus.S_RRESP, prev_rresp);
                check_eq("hold_rlast", bus.S_RLAST, prev_rlast);
            end
            if (bus.S_ARVALID && bus.S_ARREADY) begin
                for (int i = 0; i <= int'(bus.S_ARLEN); i++) begin
                    beat_t       b;
                    logic [31:0] a;
                    a      = beat_addr(bus.S_ARADDR, int'(bus.S_ARLEN), int'(bus.S_ARSIZE),
                                       bus.S_ARBURST, i);
                    b.id   = bus.S_ARID;
                    b.idx  = (a >> 2) % 256;
`ifdef ERR_RESP_EN
                    b.err  = (a >> 10) != 0;
`else
                    b.err  = 1'b0;
`endif
                    b.last = (i == int'(bus.S_ARLEN));
                    exp_q.push_back(b);
                end
            end
            if (bus.S_RVALID && bus.S_RREADY) begin
                check_eq("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check_eq("rid", bus.S_RID, b.id);
                    check_eq("rdata", bus.S_RDATA, b.err ? 32'h0 : mem_model[b.idx]);
                    check_eq("rresp", bus.S_RRESP, b.err ? 4'b0010 : 4'b0000);
                    check_eq("rlast", bus.S_RLAST, b.last);
                end
                beats++;
            end
            if (bubble_win && !bus.S_RVALID && exp_q.size() > 0) bubbles++;
            stall_q    = bus.S_RVALID && !bus.S_RREADY;
            prev_rid   = bus.S_RID;
            prev_rdata = bus.S_RDATA;
            prev_rresp = bus.S_RRESP;
            prev_rlast = bus.S_RLAST;
        end
    end

    initial begin
        bus.S_RREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       bus.S_RREADY = 1'b0;
                1:       bus.S_RREADY = 1'b1;
                2:       bus.S_RREADY = ~bus.S_RREADY;
                default: bus.S_RREADY = 1'($urandom % 2);
            endcase
        end
    end

    // Callers start at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic ar_send(input logic [4:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok = 0;
        bus.S_ARID    = id;
        bus.S_ARADDR  = addr;
        bus.S_ARLEN   = len;
        bus.S_ARSIZE  = size;
        bus.S_ARBURST = burst;
        bus.S_ARVALID = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bus.S_ARREADY) begin
                ok = 1;
                break;
            end
        end
        check_eq("arready_timeout", ok, 1);
        @(posedge clk);
        #1;
        bus.S_ARVALID = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.S_RVALID) begin
                done = 1;
                break;
            end
        end
        check_eq("idle_timeout", done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic ld_word(input logic [7:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en   = 1'b0;
    endtask

    initial begin
        int n;
        bit ok;
        clr = 1'b1;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        bus.S_ARVALID = 1'b0;
        bus.S_ARID = '0;
        bus.S_ARADDR = '0;
        bus.S_ARLEN = '0;
        bus.S_ARSIZE = '0;
        bus.S_ARBURST = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_arready", bus.S_ARREADY, 0);
        check_eq("rst_rvalid", bus.S_RVALID, 0);
        check_eq("rst_rlast", bus.S_RLAST, 0);
        check_eq("rst_rid", bus.S_RID, 0);
        check_eq("rst_rresp", bus.S_RRESP, 0);
        check_eq("rst_rdata", bus.S_RDATA, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check_eq("arready_after_rst", bus.S_ARREADY, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 256; i++) ld_word(8'(i), $urandom);
        for (int i = 0; i < 4; i++) ld_word(8'(i), 32'hA0 + 32'(i));

        // Single INCR burst with first-beat latency.
        rr_mode = 1;
        ar_send(5'd5, 32'h0, 4'd3, 3'd2, 2'b01);
        @(negedge clk);
        check_eq("lat_t1_rvalid", bus.S_RVALID, 0);
        @(negedge clk);
        check_eq("lat_t2_rvalid", bus.S_RVALID, 1);
        check_eq("lat_t2_rid", bus.S_RID, 5);
        check_eq("lat_t2_rdata", bus.S_RDATA, 32'hA0);
        @(posedge clk);
        #1;
        wait_idle();

        // Queue fill, back-pressure on AR, zero-bubble burst chaining.
        rr_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        ar_send(5'd1, 32'h0, 4'd1, 3'd2, 2'b01);
        ar_send(5'd2, 32'h8, 4'd1, 3'd2, 2'b01);
        ar_send(5'd3, 32'h4, 4'd0, 3'd2, 2'b01);
        bus.S_ARID = 5'd4;
        bus.S_ARADDR = 32'h0;
        bus.S_ARLEN = 4'd2;
        bus.S_ARSIZE = 3'd2;
        bus.S_ARBURST = 2'b01;
        bus.S_ARVALID = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("full_arready", bus.S_ARREADY, 0);
        end
        check_eq("full_rid", bus.S_RID, 1);
        bubble_win = 1;
        rr_mode = 1;
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.S_ARREADY) begin
                ok = 1;
                break;
            end
        end
        check_eq("ar4_accept", ok, 1);
        @(posedge clk);
        #1;
        bus.S_ARVALID = 1'b0;
        wait_idle();
        bubble_win = 0;
        check_eq("bubbles", bubbles, 0);

        // Stalled beats must hold their payload.
        rr_mode = 2;
        n = beats;
        ar_send(5'd9, 32'h0, 4'd3, 3'd2, 2'b01);
        wait_idle();
        check_eq("toggle_beats", beats - n, 4);

        rr_mode = 1;
        ar_send(5'd10, 32'h8, 4'd3, 3'd2, 2'b10);
        ar_send(5'd11, 32'h4, 4'd2, 3'd2, 2'b00);
        wait_idle();

        // clr in the middle of a burst with one request queued.
        ar_send(5'd7, 32'h10, 4'd7, 3'd2, 2'b01);
        ar_send(5'd8, 32'h0, 4'd0, 3'd2, 2'b01);
        n = 0;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.S_RVALID && bus.S_RREADY) n++;
            if (n == 2) begin
                ok = 1;
                break;
            end
        end
        check_eq("clr_two_beats", ok, 1);
        rr_mode = 0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("clr_rvalid", bus.S_RVALID, 0);
        check_eq("clr_arready", bus.S_ARREADY, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check_eq("post_clr_arready", bus.S_ARREADY, 1);
        rr_mode = 1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.S_RVALID) n++;
        end
        check_eq("post_clr_no_beats", n, 0);
        @(posedge clk);
        #1;

        // Address above the array: aliasing or SLVERR depending on build.
        ar_send(5'd6, 32'h400, 4'd1, 3'd2, 2'b01);
        wait_idle();

        // Random traffic with concurrent preloads and random RREADY.
        rr_mode = 3;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    logic [31:0] a;
                    a = ($urandom % 2) ? $urandom : ($urandom % 1024);
                    repeat ($urandom % 3) begin
                        @(posedge clk);
                        #1;
                    end
                    ar_send(5'($urandom), a, 4'($urandom), 3'($urandom % 3), 2'($urandom));
                end
            end
            begin
                repeat (300) begin
                    @(posedge clk);
                    #1;
                    ld_en   = ($urandom % 4) == 0;
                    ld_addr = 8'($urandom % 16);
                    ld_data = $urandom;
                end
                @(posedge clk);
                #1;
                ld_en = 1'b0;
            end
        join
        rr_mode = 1;
        wait_idle();
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
